// File: rtl/uart_transmitter.sv
`timescale 1ns/1ps
// uart_transmitter: 7-bit UART serializer with a one-entry holding buffer for gapless frames.
// Define UART_TX_HAMMING_EN to Hamming(7,4)-encode in_data[3:0] before it is buffered.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [6:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_out
);
  typedef enum logic [1:0] {IDLE = 2'b00, START = 2'b01, DATA = 2'b10, STOP = 2'b11} state_t;
  localparam int SW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam logic [SW-1:0] BIT_LAST  = SW'(CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS * CLKS_PER_BIT - 1);
  state_t        r_state, w_state;
  logic [SW-1:0] r_samp, w_samp;
  logic [2:0]    r_bit_cnt, w_bit_cnt;
  logic [6:0]    r_shift, w_shift, r_buf, w_buf, w_code;
  logic          r_tx, w_tx, r_buf_valid, w_buf_valid;
  logic          w_acc, w_bit_end, w_stop_end;
`ifdef UART_TX_HAMMING_EN
  logic [2:0] w_unused;
  assign w_unused = in_data[6:4];
  assign w_code = {in_data[3], in_data[2], in_data[1], in_data[1] ^ in_data[2] ^ in_data[3],
                   in_data[0], in_data[0] ^ in_data[2] ^ in_data[3], in_data[0] ^ in_data[1] ^ in_data[3]};
`else
  assign w_code = in_data;
`endif
  assign in_ready   = rst_n & ena & ~r_buf_valid;
  assign w_acc      = in_valid & in_ready;
  assign w_bit_end  = r_samp == BIT_LAST;
  assign w_stop_end = r_samp == STOP_LAST;
  assign busy       = (r_state != IDLE) | r_buf_valid;
  assign done       = ena & (r_state == STOP) & w_stop_end;
  assign tx         = r_tx;
  assign state_out  = r_state;
  always_comb begin
    w_state     = r_state;
    w_samp      = r_samp;
    w_bit_cnt   = r_bit_cnt;
    w_shift     = r_shift;
    w_tx        = r_tx;
    w_buf       = w_acc ? w_code : r_buf;
    w_buf_valid = r_buf_valid | w_acc;
    case (r_state)
      IDLE: begin
        w_tx = ~r_buf_valid;
        if (r_buf_valid) begin
          w_state     = START;
          w_shift     = r_buf;
          w_buf_valid = 1'b0;
          w_bit_cnt   = 3'd0;
          w_samp      = '0;
        end
      end
      START: begin
        w_samp = w_bit_end ? '0 : r_samp + 1'b1;
        if (w_bit_end) begin
          w_state = DATA;
          w_tx    = r_shift[0];
        end
      end
      DATA: begin
        w_samp = w_bit_end ? '0 : r_samp + 1'b1;
        if (w_bit_end && r_bit_cnt == 3'd6) begin
          w_state = STOP;
          w_tx    = 1'b1;
        end else if (w_bit_end) begin
          w_shift   = r_shift >> 1;
          w_bit_cnt = r_bit_cnt + 3'd1;
          w_tx      = r_shift[1];
        end
      end
      STOP: begin
        w_samp = w_stop_end ? '0 : r_samp + 1'b1;
        // a queued word starts on the very next cycle, so frames abut
        if (w_stop_end && r_buf_valid) begin
          w_state     = START;
          w_shift     = r_buf;
          w_buf_valid = 1'b0;
          w_bit_cnt   = 3'd0;
          w_tx        = 1'b0;
        end else if (w_stop_end) begin
          w_state = IDLE;
          w_tx    = 1'b1;
        end
      end
      default: begin
        w_state = IDLE;
        w_tx    = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_samp      <= '0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 7'd0;
      r_buf       <= 7'd0;
      r_buf_valid <= 1'b0;
      r_tx        <= 1'b1;
    end else if (ena) begin
      r_state     <= w_state;
      r_samp      <= w_samp;
      r_bit_cnt   <= w_bit_cnt;
      r_shift     <= w_shift;
      r_buf       <= w_buf;
      r_buf_valid <= w_buf_valid;
      r_tx        <= w_tx;
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
// tb_uart_transmitter: directed frames, back-to-back queueing, ena freeze and mid-frame reset.
module tb_uart_transmitter;
  logic       clk, rst_n, ena, in_valid, in_ready, tx, busy, done;
  logic [6:0] in_data;
  logic [1:0] state_out;
  int         n_cmp = 0, n_err = 0;
`ifdef UART_TX_HAMMING_EN
  localparam logic [6:0] W_A = 7'h0B, E_A = 7'h55, W_B = 7'h70, E_B = 7'h00;
  localparam logic [6:0] W_C = 7'h0E, E_C = 7'h78, W_D = 7'h06, E_D = 7'h33;
`else
  localparam logic [6:0] W_A = 7'h55, E_A = 7'h55, W_B = 7'h01, E_B = 7'h01;
  localparam logic [6:0] W_C = 7'h7E, E_C = 7'h7E, W_D = 7'h2A, E_D = 7'h2A;
`endif
  uart_transmitter dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .done(done), .state_out(state_out)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic put(input logic [6:0] w);
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("put rdy", in_ready, 0);
  endtask
  // checks one frame from its start bit; frz>=0 freezes ena for 5 cycles after that cycle
  task automatic frame(input logic [6:0] w, input string tag, input int frz, output int gap);
    logic [8:0] line;
    logic [6:0] rx;
    int         good[9];
    int         dn_at, dn_cnt;
    line = {1'b1, w, 1'b0};
    rx = 7'd0;
    dn_at = -1;
    dn_cnt = 0;
    foreach (good[b]) good[b] = 0;
    gap = 0;
    while (tx !== 1'b0 && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    chk({tag, " start"}, int'(gap < 200), 1);
    for (int i = 0; i < 72; i++) begin
      if (i > 0) @(negedge clk);
      if (tx === line[i / 8]) good[i / 8]++;
      if (i % 8 == 4 && i / 8 >= 1 && i / 8 <= 7) rx[i / 8 - 1] = tx;
      if (done === 1'b1) begin
        dn_cnt++;
        dn_at = i;
      end
      if (i == frz) begin
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk({tag, " frz tx"}, tx, line[i / 8]);
          chk({tag, " frz st"}, state_out, 2);
          chk({tag, " frz done"}, done, 0);
          chk({tag, " frz rdy"}, in_ready, 0);
        end
        ena = 1'b1;
      end
    end
    for (int b = 0; b < 9; b++) chk($sformatf("%s bit%0d cycles", tag, b), good[b], 8);
    chk({tag, " done cnt"}, dn_cnt, 1);
    chk({tag, " done at"}, dn_at, 71);
    chk({tag, " rx word"}, rx, w);
  endtask
  initial begin
    int g, bad_tx, bad_busy, bad_st, bad_rdy, bad_done;
    rst_n = 1'b0; ena = 1'b0; in_valid = 1'b0; in_data = 7'd0;
    repeat (3) @(negedge clk);
    chk("rst tx", tx, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst rdy", in_ready, 0);
    chk("rst st", state_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ena0 rdy", in_ready, 0);
    ena = 1'b1;
    bad_tx = 0; bad_busy = 0; bad_st = 0; bad_rdy = 0; bad_done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bad_tx   += int'(tx !== 1'b1);
      bad_busy += int'(busy !== 1'b0);
      bad_st   += int'(state_out !== 2'b00);
      bad_rdy  += int'(in_ready !== 1'b1);
      bad_done += int'(done !== 1'b0);
    end
    chk("idle tx", bad_tx, 0);
    chk("idle busy", bad_busy, 0);
    chk("idle st", bad_st, 0);
    chk("idle rdy", bad_rdy, 0);
    chk("idle done", bad_done, 0);
    put(W_A);
    chk("A busy", busy, 1);
    frame(E_A, "A", -1, g);
    chk("A latency", g, 1);
    @(negedge clk);
    chk("A end st", state_out, 0);
    chk("A end busy", busy, 0);
    chk("A end tx", tx, 1);
    put(W_B);
    fork
      frame(E_B, "B", -1, g);
      begin
        repeat (20) @(negedge clk);
        chk("B mid rdy", in_ready, 1);
        put(W_C);
        in_data  = 7'h5A;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("B held rdy", in_ready, 0);
        in_valid = 1'b0;
      end
    join
    frame(E_C, "C", -1, g);
    chk("C gap", g, 1);
    repeat (3) @(negedge clk);
    chk("C end st", state_out, 0);
    put(W_D);
    frame(E_D, "D", 35, g);
    repeat (3) @(negedge clk);
    put(W_A);
    repeat (10) @(negedge clk);
    put(W_B);
    repeat (32) @(negedge clk);
    chk("R pre st", state_out, 2);
    rst_n = 1'b0;
    #1;
    chk("R tx", tx, 1);
    chk("R st", state_out, 0);
    chk("R busy", busy, 0);
    chk("R rdy", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad_tx = 0; bad_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bad_tx   += int'(tx !== 1'b1);
      bad_busy += int'(busy !== 1'b0);
    end
    chk("R after tx", bad_tx, 0);
    chk("R after busy", bad_busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
